// File: rtl/dbg_pkg.sv
// -----------------------------------------------------------------------------
// dbg_pkg
// Shared definitions for the UART debug register-bus initiator:
//   - command opcodes and response bytes exchanged over the UART
//   - register bus address/data widths
//   - state enums for the command FSM and the byte receiver
// -----------------------------------------------------------------------------
package dbg_pkg;

  localparam int AddrW = 32;
  localparam int DataW = 32;

  localparam logic [7:0] OpWrite = 8'h57;  // 'W'
  localparam logic [7:0] OpRead  = 8'h52;  // 'R'
  localparam logic [7:0] RspAck  = 8'h4B;  // 'K'
  localparam logic [7:0] RspErr  = 8'h45;  // 'E'

  typedef enum logic [2:0] {
    StCmd,
    StAddr,
    StWdata,
    StBus,
    StResp
  } cmd_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  function automatic logic is_valid_op(input logic [7:0] op);
    return (op == OpWrite) || (op == OpRead);
  endfunction

endpackage

// File: rtl/dbg_uart_phy.sv
// -----------------------------------------------------------------------------
// dbg_uart_phy
// Byte-level 8N1 UART receiver and transmitter, LSB first, c_baud_cyc clocks
// per bit on both directions.
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   c_baud_cyc             clocks per bit (static, 2..255)
//   i_uart_rx              asynchronous serial input, idle high
//   o_uart_tx              serial output, idle high
//   o_rx_valid/o_rx_data   one-cycle pulse with a correctly framed byte
//   o_rx_ferr              one-cycle pulse when a stop bit was sampled low
//   i_tx_valid/i_tx_data   byte to send, accepted when o_tx_ready is high
//   o_tx_ready             TX idle, or in the last clock of a stop bit
// -----------------------------------------------------------------------------
module dbg_uart_phy
  import dbg_pkg::*;
#(
  parameter int BaudW = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [BaudW-1:0] c_baud_cyc,
  input  logic             i_uart_rx,
  output logic             o_uart_tx,
  output logic             o_rx_valid,
  output logic [7:0]       o_rx_data,
  output logic             o_rx_ferr,
  input  logic             i_tx_valid,
  input  logic [7:0]       i_tx_data,
  output logic             o_tx_ready
);

  logic             r_rx_s1, r_rx_s2, r_rx_prev;
  rx_state_e        r_rx_state, w_rx_next;
  logic [BaudW-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic             r_rx_valid, r_rx_ferr;
  logic             w_rx_fall, w_rx_zero;
  logic [BaudW-1:0] w_baud_last, w_half_last;

  logic [9:0]       r_tx_frame;
  logic [3:0]       r_tx_bits;
  logic [BaudW-1:0] r_tx_cnt;
  logic             r_tx_busy;
  logic             w_tx_last, w_tx_ready;

  assign w_baud_last = c_baud_cyc - BaudW'(1);
  assign w_half_last = (c_baud_cyc >> 1) - BaudW'(1);
  assign w_rx_fall   = r_rx_prev & ~r_rx_s2;
  assign w_rx_zero   = (r_rx_cnt == '0);

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= i_uart_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // Receiver state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rx_state <= RxIdle;
    else          r_rx_state <= w_rx_next;
  end

  // A start bit that is high again at mid-bit was a glitch: back to idle.
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RxIdle:  if (w_rx_fall) w_rx_next = RxStart;
      RxStart: if (w_rx_zero) w_rx_next = r_rx_s2 ? RxIdle : RxData;
      RxData:  if (w_rx_zero && (r_rx_bit == 3'd7)) w_rx_next = RxStop;
      RxStop:  if (w_rx_zero) w_rx_next = RxIdle;
      default: w_rx_next = RxIdle;
    endcase
  end

  // Bit timing and data capture; every later sample lands mid-bit because
  // the first wait is half a bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      case (r_rx_state)
        RxIdle: if (w_rx_fall) r_rx_cnt <= w_half_last;
        RxStart: begin
          if (w_rx_zero) begin
            r_rx_cnt <= w_baud_last;
            r_rx_bit <= '0;
          end else begin
            r_rx_cnt <= r_rx_cnt - BaudW'(1);
          end
        end
        RxData: begin
          if (w_rx_zero) begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
            r_rx_cnt   <= w_baud_last;
          end else begin
            r_rx_cnt <= r_rx_cnt - BaudW'(1);
          end
        end
        RxStop: begin
          if (w_rx_zero) begin
            r_rx_valid <= r_rx_s2;
            r_rx_ferr  <= ~r_rx_s2;
          end else begin
            r_rx_cnt <= r_rx_cnt - BaudW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rx_valid = r_rx_valid;
  assign o_rx_data  = r_rx_shift;
  assign o_rx_ferr  = r_rx_ferr;

  // Ready during the stop bit's last clock lets the next start bit follow
  // with no idle gap.
  assign w_tx_last  = r_tx_busy && (r_tx_cnt == '0) && (r_tx_bits == '0);
  assign w_tx_ready = ~r_tx_busy | w_tx_last;

  // Transmitter: shifts a {stop, data, start} frame out LSB first, filling
  // with ones so the line rests high once the frame is gone.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_frame <= '1;
      r_tx_bits  <= '0;
      r_tx_cnt   <= '0;
      r_tx_busy  <= 1'b0;
    end else if (w_tx_ready && i_tx_valid) begin
      r_tx_frame <= {1'b1, i_tx_data, 1'b0};
      r_tx_bits  <= 4'd9;
      r_tx_cnt   <= w_baud_last;
      r_tx_busy  <= 1'b1;
    end else if (r_tx_busy) begin
      if (r_tx_cnt == '0) begin
        if (r_tx_bits == '0) begin
          r_tx_busy <= 1'b0;
        end else begin
          r_tx_frame <= {1'b1, r_tx_frame[9:1]};
          r_tx_bits  <= r_tx_bits - 4'd1;
          r_tx_cnt   <= w_baud_last;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt - BaudW'(1);
      end
    end
  end

  assign o_uart_tx  = r_tx_frame[0];
  assign o_tx_ready = w_tx_ready;

endmodule

// File: rtl/dbg_uart_master.sv
// -----------------------------------------------------------------------------
// dbg_uart_master
// UART-controlled initiator on the enable/ready register bus. Accepts
// 'W' + addr[4] + data[4] or 'R' + addr[4] (MSB first), performs one bus
// transfer and answers 'K' (write), 4 data bytes MSB first (read) or 'E'
// (unknown opcode, no transfer).
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   c_baud_cyc             clocks per UART bit (static, 2..255)
//   i_uart_rx, o_uart_tx   serial link, idle high
//   o_penable              transfer request, high while in the bus phase
//   o_pwrite/o_paddr/o_pwdata   transfer attributes, held while o_penable
//   i_pready, i_prdata     responder completion and read data
// -----------------------------------------------------------------------------
module dbg_uart_master
  import dbg_pkg::*;
#(
  parameter int BaudW = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [BaudW-1:0] c_baud_cyc,
  output logic             o_uart_tx,
  input  logic             i_uart_rx,
  output logic             o_penable,
  output logic             o_pwrite,
  output logic [AddrW-1:0] o_paddr,
  output logic [DataW-1:0] o_pwdata,
  input  logic             i_pready,
  input  logic [DataW-1:0] i_prdata
);

  logic       w_rx_valid, w_rx_ferr, w_tx_valid, w_tx_ready;
  logic [7:0] w_rx_data, w_tx_data;

  cmd_state_e       r_state, w_next;
  logic [1:0]       r_cnt;
  logic             r_write;
  logic [AddrW-1:0] r_addr;
  logic [DataW-1:0] r_wdata;
  logic [DataW-1:0] r_resp;
  logic [2:0]       r_resp_left;

  dbg_uart_phy #(.BaudW(BaudW)) u_phy (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .c_baud_cyc (c_baud_cyc),
    .i_uart_rx  (i_uart_rx),
    .o_uart_tx  (o_uart_tx),
    .o_rx_valid (w_rx_valid),
    .o_rx_data  (w_rx_data),
    .o_rx_ferr  (w_rx_ferr),
    .i_tx_valid (w_tx_valid),
    .i_tx_data  (w_tx_data),
    .o_tx_ready (w_tx_ready)
  );

  // Command FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StCmd;
    else          r_state <= w_next;
  end

  // Bytes arriving in BUS or RESP are simply not looked at. RESP ends only
  // when the last byte's stop bit finishes, i.e. when the TX is ready again.
  always_comb begin
    w_next = r_state;
    case (r_state)
      StCmd: begin
        if (w_rx_valid) w_next = is_valid_op(w_rx_data) ? StAddr : StResp;
      end
      StAddr: begin
        if (w_rx_ferr)                           w_next = StCmd;
        else if (w_rx_valid && (r_cnt == 2'd3))  w_next = r_write ? StWdata : StBus;
      end
      StWdata: begin
        if (w_rx_ferr)                           w_next = StCmd;
        else if (w_rx_valid && (r_cnt == 2'd3))  w_next = StBus;
      end
      StBus: begin
        if (i_pready) w_next = StResp;
      end
      StResp: begin
        if ((r_resp_left == '0) && w_tx_ready) w_next = StCmd;
      end
      default: w_next = StCmd;
    endcase
  end

  // Assembly registers and response shifter. Address and data shift in
  // MSB first; after four bytes the previous contents are fully replaced.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_resp      <= '0;
      r_resp_left <= '0;
    end else begin
      case (r_state)
        StCmd: begin
          if (w_rx_valid) begin
            if (is_valid_op(w_rx_data)) begin
              r_write <= (w_rx_data == OpWrite);
              r_cnt   <= '0;
            end else begin
              r_resp      <= {RspErr, {(DataW-8){1'b0}}};
              r_resp_left <= 3'd1;
            end
          end
        end
        StAddr: begin
          if (w_rx_ferr) begin
            r_cnt <= '0;
          end else if (w_rx_valid) begin
            r_addr <= {r_addr[AddrW-9:0], w_rx_data};
            r_cnt  <= r_cnt + 2'd1;
          end
        end
        StWdata: begin
          if (w_rx_ferr) begin
            r_cnt <= '0;
          end else if (w_rx_valid) begin
            r_wdata <= {r_wdata[DataW-9:0], w_rx_data};
            r_cnt   <= r_cnt + 2'd1;
          end
        end
        StBus: begin
          if (i_pready) begin
            if (r_write) begin
              r_resp      <= {RspAck, {(DataW-8){1'b0}}};
              r_resp_left <= 3'd1;
            end else begin
              r_resp      <= i_prdata;
              r_resp_left <= 3'd4;
            end
          end
        end
        StResp: begin
          if (w_tx_valid && w_tx_ready) begin
            r_resp      <= {r_resp[DataW-9:0], 8'h00};
            r_resp_left <= r_resp_left - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_tx_valid = (r_state == StResp) && (r_resp_left != '0);
  assign w_tx_data  = r_resp[DataW-1:DataW-8];

  assign o_penable = (r_state == StBus);
  assign o_pwrite  = r_write;
  assign o_paddr   = r_addr;
  assign o_pwdata  = r_wdata;

endmodule

// File: doc/dbg_uart_master.md
# dbg_uart_master

UART-to-register-bus initiator for chip configuration. It receives framed command bytes on a UART pin and issues single register read or write transfers on the chip's simple enable/ready register bus. Every register block in the design is a responder on this bus. It returns an acknowledge byte or read data over the UART TX pin. It sits at the top of each register island, next to the island's register block.

## Interface
- `BaudW`, default 8: width of `c_baud_cyc`.
- `i_clk`  in  1  sole clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `c_baud_cyc`  in  BaudW  clocks per UART bit. Static. Legal range is 2 to 255.
- `o_uart_tx`  out  1  UART transmit, idle high.
- `i_uart_rx`  in  1  UART receive, asynchronous, idle high.
- `o_penable`  out  1  transfer request.
- `o_pwrite`  out  1  1 = write, 0 = read. Valid while `o_penable` is high.
- `o_paddr`  out  32  byte address. Valid while `o_penable` is high.
- `o_pwdata`  out  32  write data. Valid while `o_penable` is high.
- `i_pready`  in  1  responder done. Sampled only while `o_penable` is high.
- `i_prdata`  in  32  read data. Valid in the cycle where `o_penable & i_pready` for a read.

## Operation
- **UART format:** 8N1, LSB first. Each bit lasts exactly `c_baud_cyc` clocks on both RX and TX.
- **RX synchronizer:** `i_uart_rx` passes through a 2-flop synchronizer.
- **RX start detection:** a falling edge arms the receiver. It waits `c_baud_cyc/2` clocks, then re-checks the line. If the line is high again, it was a glitch and the receiver re-arms. If still low, it then samples every `c_baud_cyc` clocks.
- **RX framing:** if the stop bit is sampled low, that is a framing error. The byte is dropped and the command FSM returns to CMD.
- **Command frame:** opcode byte, then 4 address bytes MSB first, then (writes only) 4 data bytes MSB first.
  - `8'h57` 'W' = write.
  - `8'h52` 'R' = read.
- **Responses:**
  - Write: one byte `8'h4B` 'K'.
  - Read: 4 data bytes, MSB first.
  - Unknown opcode: one byte `8'h45` 'E', with no bus transfer.
- **Command FSM states:** CMD, ADDR, WDATA, BUS, RESP.
  - CMD → ADDR on a valid opcode.
  - CMD → RESP (sending 'E') on an invalid opcode.
  - ADDR → WDATA after the 4th address byte for a write; ADDR → BUS after the 4th address byte for a read.
  - WDATA → BUS after the 4th data byte.
  - BUS → RESP on `o_penable & i_pready`.
  - RESP → CMD after the last response byte's stop bit completes.
- **Byte counter:** a 2-bit counter in ADDR and WDATA. It wraps from 3 to 0 on each state change.
- **Bytes during BUS or RESP:** bytes received in these states are discarded. There is no RX buffer.
- **Transfer rules:**
  - `o_penable` rises the cycle after the final command byte is accepted.
  - `o_pwrite`, `o_paddr` and `o_pwdata` are stable for the whole time `o_penable` is high.
  - `o_penable` falls the cycle after `i_pready` is sampled high.
  - There is no timeout. A responder that never raises `i_pready` holds the FSM in BUS until reset.
- **Read capture:** `i_prdata` is captured into a 32-bit shift register in the completion cycle. RESP shifts it out MSB byte first.
- **Reset:** asynchronous; any transaction in flight is abandoned, with no partial response. Reset values:
  - `o_uart_tx` = 1.
  - `o_penable` = 0, `o_pwrite` = 0, `o_paddr` = 0, `o_pwdata` = 0.
  - FSM = CMD, RX and TX idle.

## Timing
- **Write to a zero-wait responder:** `o_penable` is high for exactly 1 cycle.
- **Read to a responder that drops `i_pready` for one cycle:** `o_penable` is high for exactly 2 cycles.
- **Transfer spacing:** at least 1 idle cycle (`o_penable` = 0) separates consecutive transfers. This is guaranteed by the UART framing.
- **TX start:** the TX start bit begins the cycle after the FSM enters RESP.
- **Back-to-back response bytes:** these have no idle gap. The next start bit follows the stop bit's last clock directly.
- **Byte length:** one full byte is 10×`c_baud_cyc` clocks. With `c_baud_cyc` = 3 that is 30 clocks.
- **RX to bus latency:** the RX byte is valid 1 cycle after the stop-bit sample point. `o_penable` is asserted 1 cycle after that.

## Structure
- **Package `dbg_pkg`:**
  - Opcode and response constants (`OpWrite`, `OpRead`, `RspAck`, `RspErr`).
  - FSM state enum.
  - Bus width constants (32-bit address and data).
- **Sub-module `dbg_uart_phy`:** byte-level RX (synchronizer, start detection, framing check; outputs byte valid and byte data) plus byte-level TX (byte valid/ready handshake). It is parameterized by `BaudW`.
- **`dbg_uart_master` itself:** the command FSM, assembly registers, and bus handshake only.

## Test plan
1. Send W, 0x00002004, 0x000001A5 with `c_baud_cyc` = 3.
   - Exactly one cycle with `o_penable`=1, `o_pwrite`=1, `o_paddr`=0x00002004, `o_pwdata`=0x000001A5.
   - TX returns 0x4B.
2. Send R, 0x00002004; the responder holds `i_pready` low 1 cycle, then returns 0x000001A5.
   - `o_penable` is high for 2 cycles with `o_pwrite`=0.
   - TX returns 0x00, 0x00, 0x01, 0xA5.
3. Send opcode 0x33.
   - No `o_penable` pulse; TX returns 0x45.
   - A following valid W command completes normally.
4. Send W, then the second address byte with its stop bit forced low.
   - No bus transfer, no response.
   - A following R command works.
5. Send a read to a responder that stalls `i_pready` low for 10 cycles.
   - `o_penable` stays high for 11 cycles with stable address.
   - Bytes injected on RX during the stall are ignored; data returns correctly.
6. Assert `i_rst_n` low mid-RESP (after the 2nd read byte).
   - `o_uart_tx` goes to 1 immediately and all bus outputs go to 0.
   - No further TX bytes; the next command is handled from CMD.
